// File: rtl/proc_ctrl_pkg.sv
// Shared constants for the instruction-step controller: opcodes, step encoding, IR layout.
package proc_ctrl_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IR_W   = 9;
  localparam int unsigned NREG   = 8;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_t;

  // Instruction register layout: III XXX YYY
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
  } ir_t;

endpackage

// File: rtl/bus_ctrl_if.sv
// Control/handshake bundle between the step controller (master) and the datapath (slave).
interface bus_ctrl_if;
  import proc_ctrl_pkg::*;

  logic              run;
  logic [DATA_W-1:0] din;
  logic              g_zero;
  logic              din_out;
  logic [NREG-1:0]   r_out;
  logic              g_out;
  logic [NREG-1:0]   r_in;
  logic              a_in;
  logic              g_in;
  logic              addsub;
  logic              done;

  modport master (
    input  run, din, g_zero,
    output din_out, r_out, g_out, r_in, a_in, g_in, addsub, done
  );

  modport slave (
    output run, din, g_zero,
    input  din_out, r_out, g_out, r_in, a_in, g_in, addsub, done
  );
endinterface

// File: rtl/dec3to8.sv
// 3-bit binary to 8-bit one-hot decoder used for register select lines.
module dec3to8 (
  input  logic [2:0] sel,
  output logic [7:0] onehot
);
  assign onehot = 8'(1) << sel;
endmodule

// File: rtl/bus_ctrl.sv
// Four-step instruction controller (mv, mvi, add, sub; mvnz when MVNZ_EN is defined).
// Outputs are decoded from the registered step and IR, so reset clears them immediately.
module bus_ctrl
  import proc_ctrl_pkg::*;
(
  input  logic      clock,
  input  logic      reset,
  bus_ctrl_if.master bus
);

  step_t           step, step_nxt;
  ir_t             ir;
  logic [NREG-1:0] x_sel, y_sel;

  logic            din_out, g_out, a_in, g_in, addsub, done;
  logic [NREG-1:0] r_out, r_in;

  logic unused_in;
  assign unused_in = ^{bus.din[DATA_W-1:IR_W], bus.g_zero};

  dec3to8 u_dec_x (.sel(ir.x), .onehot(x_sel));
  dec3to8 u_dec_y (.sel(ir.y), .onehot(y_sel));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step <= T0;
      ir   <= '0;
    end else begin
      step <= step_nxt;
      if (step == T0 && bus.run) ir <= ir_t'(bus.din[IR_W-1:0]);
    end
  end

  always_comb begin
    step_nxt = step;
    din_out  = 1'b0;
    r_out    = '0;
    g_out    = 1'b0;
    r_in     = '0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    addsub   = 1'b0;
    done     = 1'b0;
    case (step)
      T0: if (bus.run) step_nxt = T1;
      T1: begin
        step_nxt = T0;
        case (ir.op)
          OP_MV: begin
            r_out = y_sel;
            r_in  = x_sel;
            done  = 1'b1;
          end
          OP_MVI: begin
            din_out = 1'b1;
            r_in    = x_sel;
            done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            r_out    = x_sel;
            a_in     = 1'b1;
            step_nxt = T2;
          end
`ifdef MVNZ_EN
          // Conditional move: the only output path that depends on a live input
          OP_MVNZ: begin
            done = 1'b1;
            if (!bus.g_zero) begin
              r_out = y_sel;
              r_in  = x_sel;
            end
          end
`endif
          default: done = 1'b1;
        endcase
      end
      T2: begin
        r_out    = y_sel;
        g_in     = 1'b1;
        addsub   = (ir.op == OP_SUB);
        step_nxt = T3;
      end
      T3: begin
        g_out    = 1'b1;
        r_in     = x_sel;
        done     = 1'b1;
        step_nxt = T0;
      end
      default: step_nxt = T0;
    endcase
  end

  assign bus.din_out = din_out;
  assign bus.r_out   = r_out;
  assign bus.g_out   = g_out;
  assign bus.r_in    = r_in;
  assign bus.a_in    = a_in;
  assign bus.g_in    = g_in;
  assign bus.addsub  = addsub;
  assign bus.done    = done;

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed and randomized self-checking bench for bus_ctrl (honours MVNZ_EN if defined).
module tb_bus_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  bus_ctrl_if bus ();

  bus_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {din_out, r_out, g_out, r_in, a_in, g_in, addsub, done}
  function automatic logic [21:0] outs();
    return {bus.din_out, bus.r_out, bus.g_out, bus.r_in,
            bus.a_in, bus.g_in, bus.addsub, bus.done};
  endfunction

  function automatic logic [21:0] ev(input logic dout, input logic [7:0] ro,
                                     input logic go, input logic [7:0] ri,
                                     input logic ai, input logic gi,
                                     input logic as, input logic dn);
    return {dout, ro, go, ri, ai, gi, as, dn};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clock);
    #1;
  endtask

  int unsigned accepted;
  int unsigned dones;
  int          mstep;
  int          mstep_nxt;
  logic [2:0]  mop;
  logic        exp_done;
  logic [15:0] rdin;
  logic        rrun;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    bus.run    = 1'b0;
    bus.din    = '0;
    bus.g_zero = 1'b0;
    #2;
    check("reset_outs", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
    step_clk();
    check("reset_hold", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
    reset = 1'b0;
    step_clk();
    check("idle_t0", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

    // mvi R0, #5
    bus.run = 1'b1; bus.din = 16'h0040;
    step_clk();
    bus.run = 1'b0; bus.din = 16'h0005;
    check("mvi_t1", 32'(outs()), 32'(ev(1, 8'h00, 0, 8'h01, 0, 0, 0, 1)));
    step_clk();
    check("mvi_after", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

    // mv R3, R0
    bus.run = 1'b1; bus.din = 16'h0018;
    step_clk();
    bus.run = 1'b0;
    check("mv_t1", 32'(outs()), 32'(ev(0, 8'h01, 0, 8'h08, 0, 0, 0, 1)));
    step_clk();
    check("mv_after", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

    // sub R1, R2 with run held high; new din must not disturb IR
    bus.run = 1'b1; bus.din = 16'h00CA;
    step_clk();
    bus.din = 16'h0000;
    check("sub_t1", 32'(outs()), 32'(ev(0, 8'h02, 0, 8'h00, 1, 0, 0, 0)));
    step_clk();
    check("sub_t2", 32'(outs()), 32'(ev(0, 8'h04, 0, 8'h00, 0, 1, 1, 0)));
    step_clk();
    check("sub_t3", 32'(outs()), 32'(ev(0, 8'h00, 1, 8'h02, 0, 0, 0, 1)));
    step_clk();
    check("sub_back_t0", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
    // run still high in T0: mv R0, R0 starts immediately
    step_clk();
    bus.run = 1'b0;
    check("mv_r0r0_t1", 32'(outs()), 32'(ev(0, 8'h01, 0, 8'h01, 0, 0, 0, 1)));
    step_clk();

    // sub R3, R0 (0x0D8 decodes as opcode 011)
    bus.run = 1'b1; bus.din = 16'h00D8;
    step_clk();
    bus.run = 1'b0;
    check("sub30_t1", 32'(outs()), 32'(ev(0, 8'h08, 0, 8'h00, 1, 0, 0, 0)));
    step_clk();
    check("sub30_t2", 32'(outs()), 32'(ev(0, 8'h01, 0, 8'h00, 0, 1, 1, 0)));
    step_clk();
    check("sub30_t3", 32'(outs()), 32'(ev(0, 8'h00, 1, 8'h08, 0, 0, 0, 1)));
    step_clk();

    // add R6, R6 reads X twice
    bus.run = 1'b1; bus.din = 16'h00B6;
    step_clk();
    bus.run = 1'b0;
    check("add66_t1", 32'(outs()), 32'(ev(0, 8'h40, 0, 8'h00, 1, 0, 0, 0)));
    step_clk();
    check("add66_t2", 32'(outs()), 32'(ev(0, 8'h40, 0, 8'h00, 0, 1, 0, 0)));
    step_clk();
    check("add66_t3", 32'(outs()), 32'(ev(0, 8'h00, 1, 8'h40, 0, 0, 0, 1)));
    step_clk();

    // mv R5, R5 self-move
    bus.run = 1'b1; bus.din = 16'h002D;
    step_clk();
    bus.run = 1'b0;
    check("mv55_t1", 32'(outs()), 32'(ev(0, 8'h20, 0, 8'h20, 0, 0, 0, 1)));
    step_clk();

    // NOP opcodes 101 and 111
    bus.run = 1'b1; bus.din = 16'h0140;
    step_clk();
    bus.run = 1'b0;
    check("nop101_t1", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 1)));
    step_clk();
    bus.run = 1'b1; bus.din = 16'h01FF;
    step_clk();
    bus.run = 1'b0;
    check("nop111_t1", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 1)));
    step_clk();
    check("nop_after", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

    // mvnz R2, R1 under both g_zero values
    bus.g_zero = 1'b1;
    bus.run = 1'b1; bus.din = 16'h0111;
    step_clk();
    bus.run = 1'b0;
    check("mvnz_gz1", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 1)));
    bus.g_zero = 1'b0;
    #1;
`ifdef MVNZ_EN
    check("mvnz_gz0", 32'(outs()), 32'(ev(0, 8'h02, 0, 8'h04, 0, 0, 0, 1)));
`else
    check("mvnz_gz0", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 1)));
`endif
    step_clk();
    check("mvnz_after", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));

    // add R4, R5 interrupted by reset in T2
    bus.run = 1'b1; bus.din = 16'h00A5;
    step_clk();
    bus.run = 1'b0;
    check("add45_t1", 32'(outs()), 32'(ev(0, 8'h10, 0, 8'h00, 1, 0, 0, 0)));
    step_clk();
    check("add45_t2", 32'(outs()), 32'(ev(0, 8'h20, 0, 8'h00, 0, 1, 0, 0)));
    reset = 1'b1;
    #1;
    check("reset_mid_t2", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
    step_clk();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_clk();
      check("post_reset_idle", 32'(outs()), 32'(ev(0, 8'h00, 0, 8'h00, 0, 0, 0, 0)));
    end

    // Randomized run/din/g_zero against a step-timing model
    accepted = 0;
    dones    = 0;
    mstep    = 0;
    mop      = 3'b000;
    for (int i = 0; i < 10000; i++) begin
      rrun = ($urandom_range(0, 3) != 0);
      rdin = 16'($urandom());
      bus.run    = rrun;
      bus.din    = rdin;
      bus.g_zero = 1'($urandom_range(0, 1));
      #1;
      exp_done = (mstep == 3) || (mstep == 1 && mop != 3'b010 && mop != 3'b011);
      check("rnd_bus_onehot", 32'($onehot0({bus.din_out, bus.r_out, bus.g_out})), 32'd1);
      check("rnd_rin_onehot", 32'($onehot0(bus.r_in)), 32'd1);
      check("rnd_done", 32'(bus.done), 32'(exp_done));
      if (bus.done) dones++;
      case (mstep)
        0: begin
          mstep_nxt = rrun ? 1 : 0;
          if (rrun) begin
            accepted++;
            mop = rdin[8:6];
          end
        end
        1: mstep_nxt = (mop == 3'b010 || mop == 3'b011) ? 2 : 0;
        2: mstep_nxt = 3;
        default: mstep_nxt = 0;
      endcase
      step_clk();
      mstep = mstep_nxt;
    end
    // Drain the last instruction before balancing run vs done counts
    bus.run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done) dones++;
      step_clk();
    end
    check("rnd_done_count", 32'(dones), 32'(accepted));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
